traffic_display_driver: RTL

- Consumer of the traffic controller's display outputs: A_Time_L/H, B_Time_L/H (BCD digits) and A_Light/B_Light.
- Snapshots those outputs once per scan frame.
- Time-multiplexes the four digits onto one 7-segment bus with one-hot digit select.
- Drives red/green lamp pairs for both roads, including flashing in override mode (all digits 4'b1111) and error flagging of illegal codes.

---
 rtl/traffic_display_driver.sv | 146 ++++++++++++++
 1 files changed

// File: rtl/traffic_display_driver.sv
// Display front end for the traffic controller: per-frame snapshot of the BCD
// timers and lights, 4-digit multiplexed 7-segment scan, lamp drive and error flag.
module traffic_display_driver #(
  parameter int SCAN_DIV  = 4,
  parameter int BLINK_DIV = 8
) (
  input  logic       clock,
  input  logic       R,
  input  logic [3:0] A_Time_L,
  input  logic [3:0] A_Time_H,
  input  logic [3:0] B_Time_L,
  input  logic [3:0] B_Time_H,
  input  logic       A_Light,
  input  logic       B_Light,
  output logic [6:0] seg,
  output logic [3:0] digit_sel,
  output logic [1:0] lamp_a,
  output logic [1:0] lamp_b,
  output logic       frame_start,
  output logic       err
);

  localparam int CW = $clog2(SCAN_DIV);
  localparam int FW = $clog2(BLINK_DIV + 1);

  localparam logic [6:0] SEG_DASH  = 7'h40;
  localparam logic [6:0] SEG_BLANK = 7'h00;
  localparam logic [1:0] LAMP_RED  = 2'b01;
  localparam logic [1:0] LAMP_GRN  = 2'b10;
  localparam logic [1:0] LAMP_OFF  = 2'b00;

  logic [CW-1:0]  cnt;
  logic [1:0]     idx;
  logic [3:0][3:0] sh_dig;   // [0]=A_L, [1]=A_H, [2]=B_L, [3]=B_H
  logic           sh_a;
  logic           sh_b;
  logic           blink_on;
  logic [FW-1:0]  frame_cnt;
  logic           running;   // low from a reset edge until the first released edge

  logic           last_cnt;
  logic           snap;
  logic           bad_digit;
  logic           flash;
  logic           conflict;
  logic [3:0]     cur_dig;
  logic [3:0]     pair_low;
  logic [6:0]     dec_seg;

  function automatic logic is_bad(input logic [3:0] d);
    return (d >= 4'd10) && (d <= 4'd14);
  endfunction

  always_comb begin
    last_cnt  = (cnt == CW'(SCAN_DIV - 1));
    snap      = last_cnt && (idx == 2'd3);
    bad_digit = is_bad(A_Time_L) | is_bad(A_Time_H) | is_bad(B_Time_L) | is_bad(B_Time_H);
  end

  always_ff @(posedge clock) begin
    if (!R) begin
      running     <= 1'b0;
      cnt         <= CW'(SCAN_DIV - 1);
      idx         <= 2'd3;
      sh_dig      <= '0;
      sh_a        <= 1'b0;
      sh_b        <= 1'b0;
      blink_on    <= 1'b1;
      frame_cnt   <= '0;
      err         <= 1'b0;
      frame_start <= 1'b0;
    end else begin
      running     <= 1'b1;
      frame_start <= snap;
      if (last_cnt) begin
        cnt <= '0;
        idx <= idx + 2'd1;
      end else begin
        cnt <= cnt + 1'b1;
      end
      if (snap) begin
        sh_dig <= {B_Time_H, B_Time_L, A_Time_H, A_Time_L};
        sh_a   <= A_Light;
        sh_b   <= B_Light;
        err    <= err | bad_digit | (A_Light & B_Light);
        if (frame_cnt == FW'(BLINK_DIV - 1)) begin
          frame_cnt <= '0;
          blink_on  <= ~blink_on;
        end else begin
          frame_cnt <= frame_cnt + 1'b1;
        end
      end
    end
  end

  always_comb begin
    cur_dig  = sh_dig[idx];
    pair_low = sh_dig[{idx[1], 1'b0}];
    flash    = (sh_dig == {4{4'hF}});
    conflict = sh_a & sh_b;
    case (cur_dig)
      4'd0:    dec_seg = 7'h3F;
      4'd1:    dec_seg = 7'h06;
      4'd2:    dec_seg = 7'h5B;
      4'd3:    dec_seg = 7'h4F;
      4'd4:    dec_seg = 7'h66;
      4'd5:    dec_seg = 7'h6D;
      4'd6:    dec_seg = 7'h7D;
      4'd7:    dec_seg = 7'h07;
      4'd8:    dec_seg = 7'h7F;
      4'd9:    dec_seg = 7'h6F;
      4'hF:    dec_seg = SEG_DASH;
      default: dec_seg = SEG_BLANK;
    endcase
  end

  // Segment and digit select; a blank first slot of each digit hides switching ghosts.
  always_comb begin
    seg       = SEG_BLANK;
    digit_sel = 4'b0000;
    if (running) begin
      if (cnt != '0) digit_sel = 4'b0001 << idx;
      if (flash)
        seg = blink_on ? SEG_DASH : SEG_BLANK;
      else if (idx[0] && (cur_dig == 4'd0) && (pair_low != 4'hF))
        seg = SEG_BLANK;
      else
        seg = dec_seg;
    end
  end

  always_comb begin
    lamp_a = LAMP_RED;
    lamp_b = LAMP_RED;
    if (running && !conflict) begin
      if (flash) begin
        if (sh_a) lamp_a = blink_on ? LAMP_GRN : LAMP_OFF;
        if (sh_b) lamp_b = blink_on ? LAMP_GRN : LAMP_OFF;
      end else begin
        lamp_a = sh_a ? LAMP_GRN : LAMP_RED;
        lamp_b = sh_b ? LAMP_GRN : LAMP_RED;
      end
    end
  end

endmodule
